oam_dma_master: RTL
===================

Name: oam_dma_master

Overview:
- Bus initiator for SPR-RAM DMA.
- Snoops CPU writes to 0x4014, halts the CPU, then takes ownership of the CPU memory bus.
- Copies XFER_LEN bytes from page {data,8'h00} to the SPR-RAM data port 0x2004, read/write alternating.
- Sits between the CPU core and the memory/IO responder. Drives the bus-ownership select for the top-level address/data mux.

Parameters:
- TRIGGER_ADDR, 16'h4014, CPU write address that starts a transfer.
- DEST_ADDR, 16'h2004, destination address written for every byte.
- XFER_LEN, 256, bytes per transfer (1..256).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cpu_addr_out  in  16  CPU-driven address (snooped)
- cpu_data_out  in  8  CPU-driven write data (snooped)
- cpu_wen  in  1  CPU write strobe (snooped)
- dma_addr_out  out  16  DMA-driven address
- dma_data_out  out  8  DMA-driven write data
- dma_ren  out  1  DMA read strobe
- dma_wen  out  1  DMA write strobe
- dma_data_in  in  8  read data from responder; combinational, valid in the same cycle as dma_ren
- bus_own  out  1  1 = mux selects DMA signals onto the bus
- cpu_halt  out  1  stalls the CPU; equal to bus_own
- dma_done  out  1  one-cycle pulse after the last write
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, phase=0, page=0, idx=0, latch=0.
  - All outputs 0, including dma_addr_out and dma_data_out.
- phase: free-running toggle every clk from reset. Used for read/write alignment.
- Trigger:
  - In IDLE, a posedge with cpu_wen=1 and cpu_addr_out==TRIGGER_ADDR sets page<=cpu_data_out, idx<=0, state<=HALT.
  - The trigger is ignored in any state other than IDLE.
- States:
  - HALT: bus_own=1, no strobes. Next is READ if phase==1, else ALIGN.
  - ALIGN: bus_own=1, no strobes, next READ. Guarantees every READ cycle has phase==0.
  - READ: dma_addr_out={page,idx[7:0]}, dma_ren=1. At posedge, latch<=dma_data_in. Next WRITE.
  - WRITE: dma_addr_out=DEST_ADDR, dma_data_out=latch, dma_wen=1.
    - Responder commits at posedge.
    - If idx==XFER_LEN-1, next DONE; else idx<=idx+1, next READ.
  - DONE: bus_own=0, dma_done=1 for exactly one cycle, next IDLE.
- Outputs are registered/decoded from state only. Strobes are never both high. Strobes are 0 whenever bus_own=0.
- Latency: bus_own is high for 1 + align + 2*XFER_LEN cycles.
  - With XFER_LEN=256: 513 cycles if the trigger cycle has phase==0, 514 if phase==1.
  - First dma_ren is 1 or 2 cycles after the trigger posedge.
- idx: 9-bit counter, no wrap. Source address low byte is idx[7:0], so it stays within the page. The address never carries into page+1.
- Reset mid-transfer: abort immediately, all outputs 0. Bytes already written remain; no dma_done.
- The CPU write to TRIGGER_ADDR still reaches the responder in the trigger cycle; this block does not suppress it.

Test Plan:
- Basic transfer:
  - Stimulus: RAM 0x0200..0x02FF = i^0x5A; CPU writes 0x02 to 0x4014 on a phase==1 cycle.
  - Required: 256 writes to 0x2004 with data i^0x5A in order; bus_own high 514 cycles; dma_done pulses once; busy=0 afterwards.
- Parity:
  - Stimulus: the same trigger issued on a phase==0 cycle.
  - Required: no ALIGN; bus_own high 513 cycles; every dma_ren lands on a phase==0 cycle.
- ROM source:
  - Stimulus: write 0x80 to 0x4014.
  - Required: reads at 0x8000..0x80FF; written data matches ROM init contents.
- Non-trigger and busy triggers:
  - Stimulus: write to 0x4015, and write to 0x4013; then, mid-transfer, drive cpu_wen with addr 0x4014 and data 0x07.
  - Required: 0x4015/0x4013 writes cause no busy; the mid-transfer trigger leaves page unchanged and the source stays the original page.
- Reset mid-transfer:
  - Stimulus: assert rst_n=0 asynchronously after 100 writes.
  - Required: all outputs 0 immediately; no dma_done; a new trigger after release runs a full 256-byte transfer.
- XFER_LEN=4 build:
  - Stimulus: trigger page 0x03.
  - Required: reads 0x0300..0x0303 and 4 writes; bus_own high 9 or 10 cycles.

Source files
------------

// File: rtl/oam_dma_master.sv
// SPR-RAM DMA bus initiator: snoops a CPU write to TRIGGER_ADDR, halts the CPU
// and copies XFER_LEN bytes from page {data,8'h00} to DEST_ADDR, read/write alternating.
module oam_dma_master #(
  parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
  parameter logic [15:0] DEST_ADDR    = 16'h2004,
  parameter int unsigned XFER_LEN     = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_addr_out,
  input  logic [7:0]  cpu_data_out,
  input  logic        cpu_wen,
  output logic [15:0] dma_addr_out,
  output logic [7:0]  dma_data_out,
  output logic        dma_ren,
  output logic        dma_wen,
  input  logic [7:0]  dma_data_in,
  output logic        bus_own,
  output logic        cpu_halt,
  output logic        dma_done,
  output logic        busy
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] HALT  = 3'd1;
  localparam logic [2:0] ALIGN = 3'd2;
  localparam logic [2:0] READ  = 3'd3;
  localparam logic [2:0] WRITE = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  localparam logic [8:0] LAST_IDX = 9'(XFER_LEN - 1);

  logic [2:0] state;
  logic       phase;
  logic [7:0] page;
  logic [8:0] idx;
  logic [7:0] latch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      phase <= 1'b0;
      page  <= '0;
      idx   <= '0;
      latch <= '0;
    end else begin
      phase <= ~phase;
      case (state)
        IDLE: begin
          if (cpu_wen && (cpu_addr_out == TRIGGER_ADDR)) begin
            page  <= cpu_data_out;
            idx   <= '0;
            state <= HALT;
          end
        end
        // HALT with phase==0 would put READ on phase==1, so insert ALIGN.
        HALT:  state <= phase ? READ : ALIGN;
        ALIGN: state <= READ;
        READ: begin
          latch <= dma_data_in;
          state <= WRITE;
        end
        WRITE: begin
          if (idx == LAST_IDX) begin
            state <= DONE;
          end else begin
            idx   <= idx + 9'd1;
            state <= READ;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    dma_addr_out = '0;
    dma_data_out = '0;
    dma_ren      = 1'b0;
    dma_wen      = 1'b0;
    bus_own      = 1'b0;
    dma_done     = 1'b0;
    case (state)
      HALT, ALIGN: bus_own = 1'b1;
      READ: begin
        bus_own      = 1'b1;
        dma_ren      = 1'b1;
        dma_addr_out = {page, idx[7:0]};
      end
      WRITE: begin
        bus_own      = 1'b1;
        dma_wen      = 1'b1;
        dma_addr_out = DEST_ADDR;
        dma_data_out = latch;
      end
      DONE:    dma_done = 1'b1;
      default: ;
    endcase
  end

  assign cpu_halt = bus_own;
  assign busy     = (state != IDLE);

endmodule
